// File: rtl/vid_axis_2ch_line_arb.sv
// Line-granular round-robin merge of two AXI4-Stream video channels onto one master, with a per-line beat watchdog.
// Optional VID_ARB_SOF_SYNC_EN: each channel is discarded until its first start-of-frame beat after reset or an enable drop.
module vid_axis_2ch_line_arb #(
  parameter int DATA_WIDTH     = 24,
  parameter int MAX_LINE_BEATS = 2048,
  parameter int CNT_WIDTH      = 12
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    arb_enable,
  input  logic [DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic                    s0_axis_tlast,
  input  logic                    s0_axis_tuser,
  input  logic                    s0_axis_tvalid,
  output logic                    s0_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic                    s1_axis_tlast,
  input  logic                    s1_axis_tuser,
  input  logic                    s1_axis_tvalid,
  output logic                    s1_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tid,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [1:0]              err_long_line,
  input  logic                    err_clr,
  output logic                    grant_busy
);
  localparam int KW = DATA_WIDTH/8;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_LINE_BEATS-1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state_q;
  logic                  grant_q;
  logic                  rr_last_q;
  logic [CNT_WIDTH-1:0]  beat_cnt_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [KW-1:0]         tkeep_q;
  logic                  tlast_q;
  logic                  tuser_q;
  logic                  tid_q;
  logic                  tvalid_q;
  logic [1:0]            err_q;

  logic       ld;
  logic       in_xfer;
  logic       sel_valid;
  logic       sel_last;
  logic       accept;
  logic       force_last;
  logic [1:0] synced;
  logic [1:0] elig;

`ifdef VID_ARB_SOF_SYNC_EN
  logic [1:0] synced_q;
  logic       enable_q;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      synced_q <= 2'b00;
      enable_q <= 1'b0;
    end else begin
      enable_q <= arb_enable;
      if (enable_q && !arb_enable) begin
        synced_q <= 2'b00;
      end else begin
        if (s0_axis_tvalid && s0_axis_tuser) synced_q[0] <= 1'b1;
        if (s1_axis_tvalid && s1_axis_tuser) synced_q[1] <= 1'b1;
      end
    end
  end

  assign synced = synced_q;

  // An unsynced channel is drained, but its SOF beat is held so it can open the first granted line.
  assign s0_axis_tready = !reset && ((in_xfer && !grant_q) ? ld :
                          (!synced_q[0] && !(s0_axis_tvalid && s0_axis_tuser)));
  assign s1_axis_tready = !reset && ((in_xfer && grant_q) ? ld :
                          (!synced_q[1] && !(s1_axis_tvalid && s1_axis_tuser)));
`else
  assign synced         = 2'b11;
  assign s0_axis_tready = in_xfer && !grant_q && ld;
  assign s1_axis_tready = in_xfer && grant_q && ld;
`endif

  assign ld         = !tvalid_q || m_axis_tready;
  assign in_xfer    = (state_q == XFER);
  assign elig       = {s1_axis_tvalid & synced[1], s0_axis_tvalid & synced[0]};
  assign sel_valid  = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_last   = grant_q ? s1_axis_tlast : s0_axis_tlast;
  assign accept     = in_xfer && ld && sel_valid;
  assign force_last = !sel_last && (beat_cnt_q == LAST_CNT);

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      beat_cnt_q <= '0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      tid_q      <= 1'b0;
      tvalid_q   <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      if (err_clr) err_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (arb_enable && (|elig)) begin
            grant_q    <= (&elig) ? ~rr_last_q : elig[1];
            beat_cnt_q <= '0;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
            if (sel_last || force_last) begin
              rr_last_q <= grant_q;
              state_q   <= IDLE;
            end
            // Later assignment so a watchdog hit beats a same-cycle clear.
            if (force_last) err_q[grant_q] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        tdata_q  <= grant_q ? s1_axis_tdata : s0_axis_tdata;
        tkeep_q  <= grant_q ? s1_axis_tkeep : s0_axis_tkeep;
        tuser_q  <= grant_q ? s1_axis_tuser : s0_axis_tuser;
        tlast_q  <= sel_last || force_last;
        tid_q    <= grant_q;
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tid    = tid_q;
  assign m_axis_tvalid = tvalid_q;
  assign err_long_line = err_q;
  assign grant_busy    = in_xfer;

endmodule

// File: tb/tb_vid_axis_2ch_line_arb.sv
// Directed bench for vid_axis_2ch_line_arb (MAX_LINE_BEATS = 16); output beats are logged by a negedge monitor.
module tb_vid_axis_2ch_line_arb;
  localparam int DW   = 24;
  localparam int KW   = DW/8;
  localparam int MAXB = 16;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          arb_enable = 1'b0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
  logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0;
  logic          s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic          s0_tuser = 1'b0, s1_tuser = 1'b0;
  logic          s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic          s0_tready, s1_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast, m_tuser, m_tid, m_tvalid;
  logic          m_tready = 1'b1;
  logic [1:0]    err_long_line;
  logic          err_clr = 1'b0;
  logic          grant_busy;

  vid_axis_2ch_line_arb #(
    .DATA_WIDTH(DW), .MAX_LINE_BEATS(MAXB), .CNT_WIDTH(5)
  ) dut (
    .aclk(aclk), .reset(reset), .arb_enable(arb_enable),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tlast(s0_tlast),
    .s0_axis_tuser(s0_tuser), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tlast(s1_tlast),
    .s1_axis_tuser(s1_tuser), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tid(m_tid), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .err_long_line(err_long_line), .err_clr(err_clr),
    .grant_busy(grant_busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    logic          tid;
    logic [1:0]    err;
    int            cyc;
  } beat_t;

  beat_t obs[$];
  beat_t mon_b;
  int    cyc = 0;
  int    bp_viol = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (!reset && m_tvalid && m_tready) begin
      mon_b.data = m_tdata; mon_b.keep = m_tkeep; mon_b.last = m_tlast;
      mon_b.user = m_tuser; mon_b.tid = m_tid; mon_b.err = err_long_line; mon_b.cyc = cyc;
      obs.push_back(mon_b);
    end
    if (!reset && m_tvalid && !m_tready && (s0_tready || s1_tready)) bp_viol++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within 500000 time units");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] exp_data(input int ch, input logic [7:0] line_id, input int i);
    return {8'(ch), line_id, 8'(i)};
  endfunction

  task automatic drive(input int ch, input logic v, input logic [DW-1:0] d, input logic l,
                       input logic u, input logic [KW-1:0] k);
    if (ch == 0) begin
      s0_tvalid = v; s0_tdata = d; s0_tlast = l; s0_tuser = u; s0_tkeep = k;
    end else begin
      s1_tvalid = v; s1_tdata = d; s1_tlast = l; s1_tuser = u; s1_tkeep = k;
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    reset = 1'b1; arb_enable = 1'b0; err_clr = 1'b0; m_tready = 1'b1;
    drive(0, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    reset = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  // Sends one source line; tuser on beat sof_at; arb_enable dropped after beat drop_at-1 is taken.
  task automatic send_line(input int ch, input int n, input int sof_at, input logic [7:0] line_id,
                           input int drop_at);
    for (int i = 0; i < n; i++) begin
      bit hs;
      int t;
      hs = 1'b0;
      t  = 0;
      drive(ch, 1'b1, exp_data(ch, line_id, i), (i == n-1), (i == sof_at),
            (i == n-1) ? 3'b011 : 3'b111);
      while (!hs && t < 200) begin
        @(negedge aclk);
        hs = (ch == 0) ? s0_tready : s1_tready;
        @(posedge aclk);
        #1;
        t++;
      end
      if (!hs) begin
        checks++; errors++;
        $display("FAIL send_timeout: ch%0d line %0h beat %0d not accepted in 200 cycles", ch, line_id, i);
        drive(ch, 1'b0, '0, 1'b0, 1'b0, '0);
        return;
      end
      if (i == drop_at-1) arb_enable = 1'b0;
    end
    drive(ch, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    checks++; if (m_tkeep !== '0) begin errors++; $display("FAIL reset_tkeep: got %b want 0", m_tkeep); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    checks++; if (m_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b want 0", m_tuser); end
    checks++; if (m_tid !== 1'b0) begin errors++; $display("FAIL reset_tid: got %b want 0", m_tid); end
    checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL reset_s0_tready: got %b want 0", s0_tready); end
    checks++; if (s1_tready !== 1'b0) begin errors++; $display("FAIL reset_s1_tready: got %b want 0", s1_tready); end
    checks++; if (err_long_line !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err_long_line); end
    checks++; if (grant_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", grant_busy); end
    @(negedge aclk);
    reset = 1'b0;
    drain(3);
    checks++; if (grant_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", grant_busy); end
  endtask

  task automatic test_single_channel();
    obs.delete();
    arb_enable = 1'b1;
    for (int l = 0; l < 4; l++) send_line(0, 8, (l == 0) ? 0 : -1, 8'(l), -1);
    drain(6);
    checks++; if (obs.size() != 32) begin errors++; $display("FAIL single_count: got %0d beats want 32", obs.size()); end
    for (int b = 0; b < 32 && b < obs.size(); b++) begin
      int l, i;
      l = b / 8; i = b % 8;
      checks++;
      if (obs[b].data !== exp_data(0, 8'(l), i) || obs[b].last !== (i == 7) ||
          obs[b].user !== (b == 0) || obs[b].tid !== 1'b0 ||
          obs[b].keep !== ((i == 7) ? 3'b011 : 3'b111)) begin
        errors++;
        $display("FAIL single_beat%0d: got d=%h k=%b l=%b u=%b id=%b want d=%h l=%b u=%b id=0", b,
                 obs[b].data, obs[b].keep, obs[b].last, obs[b].user, obs[b].tid,
                 exp_data(0, 8'(l), i), (i == 7), (b == 0));
      end
    end
    for (int l = 1; l < 4 && 8*l < obs.size(); l++) begin
      checks++;
      if (obs[8*l].cyc - obs[8*l-1].cyc != 2) begin
        errors++;
        $display("FAIL single_gap%0d: got %0d cycles between lines want 2", l, obs[8*l].cyc - obs[8*l-1].cyc);
      end
    end
    checks++; if (err_long_line !== 2'b00) begin errors++; $display("FAIL single_err: got %b want 00", err_long_line); end
  endtask

  task automatic test_round_robin();
    do_reset();
    obs.delete();
    arb_enable = 1'b1;
    fork
      for (int l = 0; l < 3; l++) send_line(0, 4, (l == 0) ? 0 : -1, 8'(16 + l), -1);
      for (int l = 0; l < 3; l++) send_line(1, 4, (l == 0) ? 0 : -1, 8'(16 + l), -1);
    join
    drain(6);
    checks++; if (obs.size() != 24) begin errors++; $display("FAIL rr_count: got %0d beats want 24", obs.size()); end
    for (int b = 0; b < 24 && b < obs.size(); b++) begin
      int k, i;
      k = b / 4; i = b % 4;
      checks++;
      if (obs[b].data !== exp_data(k % 2, 8'(16 + k/2), i) || obs[b].tid !== 1'(k % 2) ||
          obs[b].last !== (i == 3)) begin
        errors++;
        $display("FAIL rr_beat%0d: got d=%h id=%b l=%b want d=%h id=%0d l=%b", b, obs[b].data, obs[b].tid,
                 obs[b].last, exp_data(k % 2, 8'(16 + k/2), i), k % 2, (i == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    bit done;
    done = 1'b0;
    obs.delete();
    bp_viol = 0;
    m_tready = 1'b1;
    fork
      begin
        send_line(1, 16, -1, 8'h20, -1);
        done = 1'b1;
      end
      while (!done) begin
        @(posedge aclk);
        #1;
        m_tready = ~m_tready;
      end
    join
    m_tready = 1'b1;
    drain(6);
    checks++; if (obs.size() != 16) begin errors++; $display("FAIL bp_count: got %0d beats want 16", obs.size()); end
    for (int b = 0; b < 16 && b < obs.size(); b++) begin
      checks++;
      if (obs[b].data !== exp_data(1, 8'h20, b) || obs[b].last !== (b == 15) || obs[b].tid !== 1'b1) begin
        errors++;
        $display("FAIL bp_beat%0d: got d=%h l=%b id=%b want d=%h l=%b id=1", b, obs[b].data, obs[b].last,
                 obs[b].tid, exp_data(1, 8'h20, b), (b == 15));
      end
    end
    checks++; if (bp_viol != 0) begin errors++; $display("FAIL bp_tready: got %0d cycles with tready while stalled want 0", bp_viol); end
    checks++; if (err_long_line !== 2'b00) begin errors++; $display("FAIL bp_limit_tlast_err: got %b want 00", err_long_line); end
  endtask

  task automatic test_watchdog();
    obs.delete();
    send_line(0, 18, -1, 8'h30, -1);
    drain(6);
    checks++; if (obs.size() != 18) begin errors++; $display("FAIL wd_count: got %0d beats want 18", obs.size()); end
    for (int b = 0; b < 18 && b < obs.size(); b++) begin
      checks++;
      if (obs[b].data !== exp_data(0, 8'h30, b) || obs[b].last !== (b == 15 || b == 17) || obs[b].tid !== 1'b0) begin
        errors++;
        $display("FAIL wd_beat%0d: got d=%h l=%b id=%b want d=%h l=%b id=0", b, obs[b].data, obs[b].last,
                 obs[b].tid, exp_data(0, 8'h30, b), (b == 15 || b == 17));
      end
    end
    if (obs.size() >= 17) begin
      checks++;
      if (obs[16].cyc - obs[15].cyc != 2) begin
        errors++; $display("FAIL wd_regrant_gap: got %0d want 2", obs[16].cyc - obs[15].cyc);
      end
    end
    checks++; if (err_long_line !== 2'b01) begin errors++; $display("FAIL wd_err_set: got %b want 01", err_long_line); end
    err_clr = 1'b1;
    @(posedge aclk);
    #1;
    err_clr = 1'b0;
    checks++; if (err_long_line !== 2'b00) begin errors++; $display("FAIL wd_err_clr: got %b want 00", err_long_line); end

    err_clr = 1'b1;
    obs.delete();
    send_line(1, 17, -1, 8'h31, -1);
    drain(6);
    err_clr = 1'b0;
    checks++; if (obs.size() != 17) begin errors++; $display("FAIL wd1_count: got %0d beats want 17", obs.size()); end
    if (obs.size() >= 17) begin
      checks++;
      if (obs[15].last !== 1'b1 || obs[15].err !== 2'b10) begin
        errors++; $display("FAIL wd_set_beats_clr: got last=%b err=%b want last=1 err=10", obs[15].last, obs[15].err);
      end
      checks++;
      if (obs[16].last !== 1'b1 || obs[16].err !== 2'b00 || obs[16].tid !== 1'b1) begin
        errors++; $display("FAIL wd1_tail: got last=%b err=%b id=%b want 1 00 1", obs[16].last, obs[16].err, obs[16].tid);
      end
    end
  endtask

  task automatic test_enable_reset();
    obs.delete();
    arb_enable = 1'b1;
    send_line(0, 8, -1, 8'h40, 3);
    drive(0, 1'b1, exp_data(0, 8'h41, 0), 1'b0, 1'b1, 3'b111);
    drain(20);
    checks++; if (obs.size() != 8) begin errors++; $display("FAIL en_count: got %0d beats want 8", obs.size()); end
    if (obs.size() >= 8) begin
      checks++;
      if (obs[7].last !== 1'b1 || obs[7].data !== exp_data(0, 8'h40, 7)) begin
        errors++; $display("FAIL en_line_end: got d=%h l=%b want d=%h l=1", obs[7].data, obs[7].last, exp_data(0, 8'h40, 7));
      end
    end
    checks++; if (grant_busy !== 1'b0) begin errors++; $display("FAIL en_no_grant: got busy=%b want 0", grant_busy); end
    checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL en_tready: got %b want 0", s0_tready); end

    arb_enable = 1'b1;
    drain(6);
    @(negedge aclk);
    checks++;
    if (m_tvalid !== 1'b1 || grant_busy !== 1'b1) begin
      errors++; $display("FAIL midline_active: got tvalid=%b busy=%b want 1 1", m_tvalid, grant_busy);
    end
    reset = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid: got %b want 0", m_tvalid); end
    checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL rst_mid_tready: got %b want 0", s0_tready); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rst_mid_tdata: got %h want 0", m_tdata); end
    checks++; if (grant_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", grant_busy); end
    repeat (2) @(posedge aclk);
    drive(0, 1'b0, '0, 1'b0, 1'b0, '0);
    arb_enable = 1'b0;
    @(negedge aclk);
    reset = 1'b0;
    drain(2);
  endtask

  task automatic test_sof_sync();
    int first;
    int n_exp;
    do_reset();
    obs.delete();
    arb_enable = 1'b1;
    send_line(1, 8, 5, 8'h50, -1);
    drain(6);
`ifdef VID_ARB_SOF_SYNC_EN
    first = 5;
`else
    first = 0;
`endif
    n_exp = 8 - first;
    checks++; if (obs.size() != n_exp) begin errors++; $display("FAIL sof_count: got %0d beats want %0d", obs.size(), n_exp); end
    for (int b = 0; b < n_exp && b < obs.size(); b++) begin
      checks++;
      if (obs[b].data !== exp_data(1, 8'h50, first + b) || obs[b].tid !== 1'b1 ||
          obs[b].user !== (first + b == 5) || obs[b].last !== (first + b == 7)) begin
        errors++;
        $display("FAIL sof_beat%0d: got d=%h id=%b u=%b l=%b want d=%h id=1 u=%b l=%b", b, obs[b].data,
                 obs[b].tid, obs[b].user, obs[b].last, exp_data(1, 8'h50, first + b), (first + b == 5),
                 (first + b == 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_enable_reset();
    test_sof_sync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vid_axis_2ch_line_arb.md
Name: vid_axis_2ch_line_arb

Overview:
- Line-granular arbiter. Merges two 24-bit AXI4-Stream video channels, one from each video-input bridge, onto a single AXIS master.
- The merged stream feeds the shared VDMA write path.
- Grants are switched only at line boundaries (tlast) using round-robin. The source channel is tagged on m_axis_tid.
- Per-channel runaway lines are guarded by a beat watchdog.

Parameters:
- DATA_WIDTH, 24, pixel bus width; multiple of 8.
- MAX_LINE_BEATS, 2048, maximum beats per line before a forced tlast; minimum 2.
- CNT_WIDTH, 12, beat counter width; must satisfy 2^CNT_WIDTH > MAX_LINE_BEATS.

Ports:
- aclk  in  1  AXIS clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- arb_enable  in  1  1 = arbitration allowed; 0 = finish the current line, then idle.
- s0_axis_tdata  in  DATA_WIDTH  channel 0 data.
- s0_axis_tkeep  in  DATA_WIDTH/8  channel 0 keep.
- s0_axis_tlast  in  1  channel 0 end of line.
- s0_axis_tuser  in  1  channel 0 start of frame.
- s0_axis_tvalid  in  1  channel 0 valid.
- s0_axis_tready  out  1  channel 0 ready.
- s1_axis_*  same as s0; channel 1.
- m_axis_tdata  out  DATA_WIDTH  merged data.
- m_axis_tkeep  out  DATA_WIDTH/8  merged keep.
- m_axis_tlast  out  1  end of line; original or forced.
- m_axis_tuser  out  1  start of frame.
- m_axis_tid  out  1  source channel of the beat.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- err_long_line  out  2  sticky per-channel watchdog flags.
- err_clr  in  1  synchronous clear of err_long_line.
- grant_busy  out  1  1 while in XFER.

Behaviour:
- Reset values: all m_axis_* = 0, s*_tready = 0, err_long_line = 0, grant_busy = 0, state = IDLE, rr_last = 1 (so channel 0 wins first), beat_cnt = 0.
- Output stage is a single register. Load condition ld = !m_axis_tvalid | m_axis_tready.
- Granted channel: s_tready = ld in XFER. Non-granted channel: s_tready = 0.
- Beat accepted = s_tvalid & s_tready. An accepted beat appears on m_axis_* on the next cycle.
- m_axis_tvalid clears on an m_axis_tready handshake when no new beat is loaded.
- State machine IDLE:
  - If arb_enable and both channels valid, grant = ~rr_last.
  - Else if arb_enable and one channel valid, grant that channel.
  - Go to XFER, beat_cnt = 0. No beat is accepted in the IDLE cycle, so there is 1 bubble per line.
- State machine XFER:
  - Each accepted beat increments beat_cnt.
  - If the accepted beat has tlast = 1: rr_last = grant, go to IDLE.
  - If the accepted beat has tlast = 0 and beat_cnt == MAX_LINE_BEATS-1: force m_axis_tlast = 1 on that beat, set err_long_line[grant], rr_last = grant, go to IDLE.
  - Remaining beats of the overlong line are forwarded as a new line on a later grant.
- tuser, tkeep and tdata are passed unchanged. m_axis_tid = grant, registered with the data.
- arb_enable deasserted mid-line: the line completes normally. No new grant is issued while arb_enable = 0.
- Simultaneous events:
  - tlast and the watchdog limit on the same beat: counts as normal end; no error.
  - err_clr and a watchdog set in the same cycle: set wins.
- Reset mid-line: outputs return to reset values immediately. The partial line is lost downstream; upstream beats are held because tready = 0.

Optional Feature:
- Macro: VID_ARB_SOF_SYNC_EN.
- Defined:
  - A per-channel "synced" flag is cleared on reset and on an arb_enable falling edge.
  - While a channel is unsynced, it is never granted. Its tready = 1 and its beats are discarded.
  - The flag sets when a beat with tuser = 1 is seen. That beat is not consumed; the channel becomes grantable in the following cycle.
- Undefined: channels are grantable immediately after reset with no discarding.

Test Plan:
- Single channel: ch0 sends 4 lines × 8 beats, tuser on the first beat; m_axis_tready = 1 → 32 beats out, tid = 0, 4 tlasts, tuser on beat 0, 1 idle cycle between lines.
- Round-robin: both channels continuously valid with 4-beat lines → output line order tid 0,1,0,1…; no beat interleaving within a line.
- Backpressure: m_axis_tready toggles 1010… during a 16-beat ch1 line → all 16 beats delivered in order, with no duplicates or drops; s1_tready = 0 whenever the output is full and not ready.
- Watchdog: MAX_LINE_BEATS = 4, ch0 sends a 6-beat line → output beat 4 has forced tlast; err_long_line = 2'b01. Remaining 2 beats form a later line. err_clr → 2'b00.
- Enable/reset: drop arb_enable at beat 3 of an 8-beat line → line completes, then no grant follows. Assert reset mid-line → m_axis_tvalid = 0 and tready = 0 in the same cycle.
- VID_ARB_SOF_SYNC_EN: ch1 sends 5 beats with tuser = 0, then a beat with tuser = 1 → the first 5 beats are dropped and output starts at the tuser beat with tid = 1.
